// File: rtl/c2c_pkg.sv
// rtl/c2c_pkg.sv - shared encodings and timing constants for the chip-to-chip handshake
package c2c_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WAIT_ACK     = 2'b01,
        WAIT_ACK_LOW = 2'b10
    } c2c_state_e;

    localparam int C2C_DATA_W         = 3;
    localparam int C2C_NOTICE_CYCLES  = 100_000_000;
    localparam int C2C_TIMEOUT_CYCLES = 200_000_000;
    localparam int C2C_ACK_DELAY      = 100_000_000;

    function automatic int timer_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/master_control_cycle_timer.sv
// rtl/master_control_cycle_timer.sv - saturating down-counter, done N cycles after load
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] n,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= n;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/master_control.sv
// rtl/master_control.sv - initiator of the request/ack/valid chip-to-chip handshake
module master_control
    import c2c_pkg::*;
#(
    parameter int DATA_W         = C2C_DATA_W,
    parameter int NOTICE_CYCLES  = C2C_NOTICE_CYCLES,
    parameter int TIMEOUT_CYCLES = C2C_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send,
    input  logic [DATA_W-1:0] data_sw,
    input  logic              ack,
    output logic              request,
    output logic              valid,
    output logic [DATA_W-1:0] data_out,
    output logic              notice,
    output logic              busy,
    output logic              error
);

    localparam int TMR_W = timer_width(NOTICE_CYCLES, TIMEOUT_CYCLES);
    // The FSM acts on done one edge after it rises, so load one less to bound the wait at TIMEOUT_CYCLES.
    localparam logic [TMR_W-1:0] TO_LOAD     = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] NOTICE_LOAD = TMR_W'(NOTICE_CYCLES);

    c2c_state_e        state, state_nx;
    logic              request_nx, valid_nx, error_nx;
    logic [DATA_W-1:0] data_nx;
    logic              to_load, to_done, notice_load, notice_done;
    logic              ack_meta, ack_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= ack;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            request  <= 1'b0;
            valid    <= 1'b0;
            error    <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_nx;
            request  <= request_nx;
            valid    <= valid_nx;
            error    <= error_nx;
            data_out <= data_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        request_nx  = request;
        valid_nx    = valid;
        error_nx    = error;
        data_nx     = data_out;
        to_load     = 1'b0;
        notice_load = 1'b0;
        case (state)
            IDLE: begin
                if (send) begin
                    state_nx   = WAIT_ACK;
                    request_nx = 1'b1;
                    data_nx    = data_sw;
                    error_nx   = 1'b0;
                    to_load    = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack_s) begin
                    state_nx    = WAIT_ACK_LOW;
                    request_nx  = 1'b0;
                    valid_nx    = 1'b1;
                    notice_load = 1'b1;
                    to_load     = 1'b1;
                end else if (to_done) begin
                    state_nx   = IDLE;
                    request_nx = 1'b0;
                    error_nx   = 1'b1;
                end
            end
            WAIT_ACK_LOW: begin
                if (!ack_s) begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                end else if (to_done) begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                    error_nx = 1'b1;
                end
            end
            default: begin
                state_nx   = IDLE;
                request_nx = 1'b0;
                valid_nx   = 1'b0;
            end
        endcase
    end

    cycle_timer #(.W(TMR_W)) u_timeout_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (to_load),
        .n     (TO_LOAD),
        .done  (to_done)
    );

    // notice is the timer's nonzero count itself, giving exactly NOTICE_CYCLES high cycles.
    cycle_timer #(.W(TMR_W)) u_notice_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (notice_load),
        .n     (NOTICE_LOAD),
        .done  (notice_done)
    );

    assign notice = ~notice_done;
    assign busy   = (state != IDLE);

endmodule
